conv_frame_ctrl: RTL and testbench

// Frame sequencer in front of the streaming convolution datapath. Passes the
// AXI-S video handshake from source to datapath with zero latency, tracks
// (row,col) of every beat, and checks geometry against cfg_width/cfg_height.
// At end of frame it injects (KERNEL_DIAMETER_N-1)/2 flush lines so the

---
 rtl/conv_frame_ctrl.sv | 157 +++++++++++++++
 tb/tb_conv_frame_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_ctrl.sv
// rtl/conv_frame_ctrl.sv - frame sequencer: zero-latency handshake pass-through,
// beat position tracking, geometry checks and end-of-frame flush-line injection.
module conv_frame_ctrl #(
  parameter int IMG_W_MAX         = 1024,
  parameter int IMG_H_MAX         = 1024,
  parameter int KERNEL_DIAMETER_N = 5,
  localparam int CW = $clog2(IMG_W_MAX + 1),
  localparam int RW = $clog2(IMG_H_MAX + 1)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic [CW-1:0] cfg_width_i,
  input  logic [RW-1:0] cfg_height_i,
  input  logic          s_tvalid_i,
  input  logic          s_tuser_i,
  input  logic          s_tlast_i,
  output logic          s_tready_o,
  output logic          d_tvalid_o,
  output logic          d_tuser_o,
  output logic          d_tlast_o,
  output logic          d_flush_o,
  input  logic          d_tready_i,
  output logic [RW-1:0] d_row_o,
  output logic [CW-1:0] d_col_o,
  output logic          frame_done_o,
  output logic          err_o
);

  localparam logic [CW-1:0] W_MAX = CW'(IMG_W_MAX);
  localparam logic [RW-1:0] H_MAX = RW'(IMG_H_MAX);
  localparam logic [RW-1:0] R_L   = RW'((KERNEL_DIAMETER_N - 1) / 2);
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [RW-1:0] ONE_R = RW'(1);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  state_t        state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [CW-1:0] w_q;
  logic [RW-1:0] h_q;
  logic          err_q;
  logic          done_q;

  logic          cfg_ok;
  logic          sof;
  logic          drop;
  logic          accept;
  logic [CW-1:0] cur_w;
  logic [RW-1:0] cur_h;
  logic          last_col;
  logic          end_data;
  logic          end_flush;
  logic          err_evt;

  assign cfg_ok = (cfg_width_i != '0) && (cfg_height_i != '0) &&
                  (cfg_width_i <= W_MAX) && (cfg_height_i <= H_MAX);

  // A valid SOF (in IDLE or ACTIVE) presents itself at (0,0) with the incoming geometry.
  always_comb begin
    s_tready_o = 1'b1;
    d_tvalid_o = 1'b0;
    d_tuser_o  = 1'b0;
    d_tlast_o  = 1'b0;
    d_flush_o  = 1'b0;
    d_row_o    = row;
    d_col_o    = col;
    cur_w      = w_q;
    cur_h      = h_q;
    sof        = 1'b0;
    drop       = 1'b0;
    case (state)
      FLUSH: begin
        s_tready_o = 1'b0;
        d_tvalid_o = 1'b1;
        d_flush_o  = 1'b1;
        d_tlast_o  = (col == w_q - ONE_C);
      end
      default: begin
        if (s_tuser_i) begin
          if (cfg_ok) begin
            sof        = 1'b1;
            cur_w      = cfg_width_i;
            cur_h      = cfg_height_i;
            d_row_o    = '0;
            d_col_o    = '0;
            d_tuser_o  = 1'b1;
            d_tvalid_o = s_tvalid_i;
            s_tready_o = d_tready_i;
            d_tlast_o  = (cfg_width_i == ONE_C);
          end else begin
            drop = s_tvalid_i;
          end
        end else if (state == ACTIVE) begin
          d_tvalid_o = s_tvalid_i;
          s_tready_o = d_tready_i;
          d_tlast_o  = (col == w_q - ONE_C);
        end else begin
          drop = s_tvalid_i;
        end
      end
    endcase
  end

  assign accept    = d_tvalid_o & d_tready_i;
  assign last_col  = (d_col_o == cur_w - ONE_C);
  assign end_data  = (d_row_o == cur_h - ONE_R);
  assign end_flush = (d_row_o == cur_h + R_L - ONE_R);
  assign err_evt   = drop
                   | (accept & ~d_flush_o & (s_tlast_i != d_tlast_o))
                   | (accept & sof & (state == ACTIVE));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state  <= IDLE;
      row    <= '0;
      col    <= '0;
      w_q    <= '0;
      h_q    <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      err_q  <= err_evt;
      done_q <= 1'b0;
      if (accept) begin
        if (sof) begin
          w_q <= cfg_width_i;
          h_q <= cfg_height_i;
        end
        if (last_col) begin
          col <= '0;
          row <= d_row_o + ONE_R;
        end else begin
          col <= d_col_o + ONE_C;
          row <= d_row_o;
        end
        // Row wraps past H-1 into the flush rows H..H+R-1 naturally.
        if (state == FLUSH) begin
          if (last_col && end_flush) begin
            state  <= IDLE;
            row    <= '0;
            col    <= '0;
            done_q <= 1'b1;
          end
        end else if (last_col && end_data) begin
          state <= FLUSH;
        end else begin
          state <= ACTIVE;
        end
      end
    end
  end

  assign err_o        = err_q;
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// tb/tb_conv_frame_ctrl.sv - randomized self-checking bench for conv_frame_ctrl
// against a frame-level expected beat list.
module tb_conv_frame_ctrl;

  localparam int CW = 11;
  localparam int RW = 11;
  localparam int R  = 2;
  localparam int MAX_CYC = 3000;

  logic          clk = 1'b0;
  logic          arst_n;
  logic [CW-1:0] cfg_width;
  logic [RW-1:0] cfg_height;
  logic          s_tvalid, s_tuser, s_tlast, s_tready;
  logic          d_tvalid, d_tuser, d_tlast, d_flush, d_tready;
  logic [RW-1:0] d_row;
  logic [CW-1:0] d_col;
  logic          frame_done, err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0]  src_q[$];
  logic [24:0] exp_q[$];

  always #5 clk = ~clk;

  conv_frame_ctrl dut (
    .clk(clk), .arst_n(arst_n),
    .cfg_width_i(cfg_width), .cfg_height_i(cfg_height),
    .s_tvalid_i(s_tvalid), .s_tuser_i(s_tuser), .s_tlast_i(s_tlast), .s_tready_o(s_tready),
    .d_tvalid_o(d_tvalid), .d_tuser_o(d_tuser), .d_tlast_o(d_tlast), .d_flush_o(d_flush),
    .d_tready_i(d_tready), .d_row_o(d_row), .d_col_o(d_col),
    .frame_done_o(frame_done), .err_o(err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Beat as seen by the datapath: {flush, tuser, tlast, row, col}
  function automatic logic [24:0] beat(bit fl, bit tu, bit tl, int r, int c);
    return {fl, tu, tl, RW'(r), CW'(c)};
  endfunction

  function automatic void push_exp(int w, int h);
    for (int r = 0; r < h + R; r++)
      for (int c = 0; c < w; c++)
        exp_q.push_back(beat(r >= h, r == 0 && c == 0, c == w - 1, r, c));
  endfunction

  function automatic void push_src(int w, int h, int n);
    for (int i = 0; i < w * h && i < n; i++)
      src_q.push_back({i == 0, (i % w) == w - 1});
  endfunction

  task automatic run(input string tag, input int exp_err, input int exp_done,
                     input int p_rdy, input int p_val);
    int errs = 0, dones = 0, both = 0, cyc = 0, tail = 0;
    bit done_due = 0, hold = 0;
    logic [24:0] held = '0, got;
    while ((src_q.size() > 0 || exp_q.size() > 0 || tail < 4) && cyc < MAX_CYC) begin
      @(negedge clk);
      s_tvalid = (src_q.size() > 0) && ($urandom_range(99) < p_val);
      {s_tuser, s_tlast} = s_tvalid ? src_q[0] : 2'b00;
      d_tready = ($urandom_range(99) < p_rdy);
      #1;
      got = {d_flush, d_tuser, d_tlast, d_row, d_col};
      if (done_due) check_eq({tag, ":done_latency"}, 32'(frame_done), 32'd1);
      done_due = 0;
      errs += int'(err);
      dones += int'(frame_done);
      both += int'(err & frame_done);
      if (hold) begin
        check_eq({tag, ":flush_hold_valid"}, 32'(d_tvalid), 32'd1);
        check_eq({tag, ":flush_hold_beat"}, 32'(got), 32'(held));
      end
      hold = d_tvalid && !d_tready && d_flush;
      held = got;
      if (d_tvalid && d_tready) begin
        if (exp_q.size() == 0) check_eq({tag, ":extra_beat"}, 32'(got), 32'h1ffffff);
        else begin
          check_eq({tag, ":beat"}, 32'(got), 32'(exp_q.pop_front()));
          if (exp_q.size() == 0 && d_flush) done_due = 1;
        end
      end
      if (s_tvalid && s_tready) void'(src_q.pop_front());
      if (src_q.size() == 0 && exp_q.size() == 0) tail++; else tail = 0;
      cyc++;
    end
    check_eq({tag, ":in_time"}, 32'(cyc < MAX_CYC), 32'd1);
    check_eq({tag, ":undelivered"}, 32'(exp_q.size()), 32'd0);
    check_eq({tag, ":err_count"}, 32'(errs), 32'(exp_err));
    check_eq({tag, ":done_count"}, 32'(dones), 32'(exp_done));
    check_eq({tag, ":err_and_done"}, 32'(both), 32'd0);
    src_q.delete();
    exp_q.delete();
    s_tvalid = 0;
  endtask

  task automatic set_cfg(input int w, input int h);
    cfg_width = CW'(w);
    cfg_height = RW'(h);
  endtask

  initial begin
    int w, h, n;
    arst_n = 0; s_tvalid = 0; s_tuser = 0; s_tlast = 0; d_tready = 0;
    set_cfg(4, 3);
    #12;
    check_eq("rst:s_tready", 32'(s_tready), 32'd1);
    check_eq("rst:d_tvalid", 32'(d_tvalid), 32'd0);
    check_eq("rst:pulses", 32'({frame_done, err}), 32'd0);
    check_eq("rst:pos", 32'({d_row, d_col}), 32'd0);
    @(negedge clk); arst_n = 1;

    push_src(4, 3, 99); push_exp(4, 3);
    run("w4h3_full", 0, 1, 100, 100);
    push_src(4, 3, 99); push_exp(4, 3);
    run("w4h3_stall", 0, 1, 50, 100);

    for (int it = 0; it < 8; it++) begin
      w = $urandom_range(1, 6);
      h = $urandom_range(1, 4);
      set_cfg(w, h);
      push_src(w, h, 99); push_exp(w, h);
      run($sformatf("rand%0d_w%0dh%0d", it, w, h), 0, 1,
          $urandom_range(30, 100), $urandom_range(30, 100));
    end

    set_cfg(4, 3);
    push_src(4, 3, 99); push_exp(4, 3);
    src_q[6] = 2'b01;
    run("early_tlast", 1, 1, 60, 80);

    push_src(4, 3, 6); push_exp(4, 3);
    n = exp_q.size();
    for (int i = n - 1; i >= 6; i--) exp_q.delete(i);
    push_src(4, 3, 99); push_exp(4, 3);
    run("resof", 1, 1, 70, 80);

    for (int i = 0; i < 3; i++) src_q.push_back(2'b00);
    run("idle_drop", 3, 0, 100, 70);
    set_cfg(0, 3);
    src_q.push_back(2'b10);
    run("w0_drop", 1, 0, 100, 100);
    set_cfg(4, 3);
    push_src(4, 3, 99); push_exp(4, 3);
    run("after_drop", 0, 1, 80, 80);

    set_cfg(3, 2);
    push_src(3, 2, 99);
    d_tready = 1;
    n = 0;
    while (!d_flush && n < 50) begin
      @(negedge clk);
      s_tvalid = src_q.size() > 0;
      {s_tuser, s_tlast} = s_tvalid ? src_q[0] : 2'b00;
      #1;
      if (s_tvalid && s_tready) void'(src_q.pop_front());
      n++;
    end
    check_eq("mid_flush:reached", 32'(d_flush), 32'd1);
    @(negedge clk); s_tvalid = 0;
    #2 arst_n = 0;
    #1;
    check_eq("mid_flush:s_tready", 32'(s_tready), 32'd1);
    check_eq("mid_flush:outs", 32'({d_tvalid, d_flush, frame_done, err}), 32'd0);
    check_eq("mid_flush:pos", 32'({d_row, d_col}), 32'd0);
    @(negedge clk); @(negedge clk); arst_n = 1;
    src_q.delete();
    push_src(3, 2, 99); push_exp(3, 2);
    run("after_reset", 0, 1, 70, 90);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
